reduce_tree: RTL and testbench

REDUCE_TREE -- requirements
Module: reduce_tree

---
 rtl/reduce_tree.sv | 200 ++++++++++++++++++++
 tb/tb_reduce_tree.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reduce_tree.sv
// Streaming lane reducer: a pipelined pairwise tree combines the lanes of each
// beat, then a frame accumulator folds beats together until the frame's last beat.
module reduce_tree #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int ACC_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [W*N-1:0]     idata,
  input  logic               ivalid,
  input  logic [N-1:0]       ilane_en,
  input  logic               ilast,
  input  logic [1:0]         imode,
  output logic [ACC_W-1:0]   odata,
  output logic               ovalid,
  output logic [15:0]        obeats
);

  localparam int L  = (N > 1) ? $clog2(N) : 0;
  localparam int LV = (L > 0) ? L : 1;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;

  function automatic logic [ACC_W-1:0] ident(input logic [1:0] m);
    logic [ACC_W-1:0] r;
    case (m)
      MODE_MAX: r = {1'b1, {(ACC_W-1){1'b0}}};
      MODE_MIN: r = {1'b0, {(ACC_W-1){1'b1}}};
      default:  r = {ACC_W{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] combine(input logic [1:0] m,
                                               input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] r;
    case (m)
      MODE_MAX: r = ($signed(a) > $signed(b)) ? a : b;
      MODE_MIN: r = ($signed(a) < $signed(b)) ? a : b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

  logic             in_frame_r;
  logic [1:0]       frame_mode_r;
  logic             first_s;
  logic [1:0]       mode_s;
  logic signed [W-1:0] lane_s;

  // level 0 is the conditioned input; level l (l >= 1) is tree register l-1
  logic [ACC_W-1:0] lvl_s  [0:L][0:N-1];
  logic [1:0]       m_s    [0:L];
  logic [L:0]       v_s;
  logic [L:0]       f_s;
  logic [L:0]       l_s;
  logic [ACC_W-1:0] nxt_s  [0:LV-1][0:N-1];

  logic [ACC_W-1:0] tree_r [0:LV-1][0:N-1];
  logic [1:0]       tm_r   [0:LV-1];
  logic [LV-1:0]    tv_r;
  logic [LV-1:0]    tf_r;
  logic [LV-1:0]    tl_r;

  logic [ACC_W-1:0] acc_r;
  logic [15:0]      cnt_r;
  logic             acc_v_r;
  logic             acc_l_r;

  // input conditioning, level wiring and next-level pairing
  always_comb begin
    first_s = !in_frame_r;
    lane_s  = '0;
    if (first_s) begin
      mode_s = (imode == 2'd3) ? MODE_SUM : imode;
    end else begin
      mode_s = frame_mode_r;
    end

    for (int k = 0; k < N; k++) begin
      lane_s = idata[W*k +: W];
      if (ilane_en[k]) begin
        lvl_s[0][k] = ACC_W'(lane_s);
      end else begin
        lvl_s[0][k] = ident(mode_s);
      end
    end
    m_s[0] = mode_s;
    v_s[0] = ivalid;
    f_s[0] = first_s;
    l_s[0] = ilast;

    for (int l = 1; l <= L; l++) begin
      for (int j = 0; j < N; j++) begin
        lvl_s[l][j] = tree_r[l-1][j];
      end
      m_s[l] = tm_r[l-1];
      v_s[l] = tv_r[l-1];
      f_s[l] = tf_r[l-1];
      l_s[l] = tl_r[l-1];
    end

    for (int l = 0; l < LV; l++) begin
      for (int j = 0; j < N; j++) begin
        nxt_s[l][j] = {ACC_W{1'b0}};
      end
    end
    // elements past the live count of a level already hold the identity,
    // so an odd trailing element is naturally paired with it
    for (int l = 0; l < L; l++) begin
      for (int j = 0; j < N; j++) begin
        nxt_s[l][j] = combine(m_s[l],
          (2*j < N)     ? lvl_s[l][(2*j < N) ? 2*j : N-1]         : ident(m_s[l]),
          (2*j + 1 < N) ? lvl_s[l][(2*j + 1 < N) ? 2*j + 1 : N-1] : ident(m_s[l]));
      end
    end
  end

  // frame tracking: in-frame flag and mode locked on the first beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_frame_r   <= 1'b0;
      frame_mode_r <= MODE_SUM;
    end else if (ivalid) begin
      in_frame_r <= !ilast;
      if (first_s) begin
        frame_mode_r <= mode_s;
      end
    end
  end

  // tree pipeline registers with per-beat side-band flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LV; l++) begin
        for (int j = 0; j < N; j++) begin
          tree_r[l][j] <= {ACC_W{1'b0}};
        end
        tm_r[l] <= MODE_SUM;
      end
      tv_r <= '0;
      tf_r <= '0;
      tl_r <= '0;
    end else begin
      for (int l = 0; l < L; l++) begin
        for (int j = 0; j < N; j++) begin
          tree_r[l][j] <= nxt_s[l][j];
        end
        tm_r[l] <= m_s[l];
        tv_r[l] <= v_s[l];
        tf_r[l] <= f_s[l];
        tl_r[l] <= l_s[l];
      end
    end
  end

  // frame accumulator and saturating beat counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= 16'd0;
      acc_v_r <= 1'b0;
      acc_l_r <= 1'b0;
    end else begin
      acc_v_r <= v_s[L];
      acc_l_r <= v_s[L] & l_s[L];
      if (v_s[L]) begin
        if (f_s[L]) begin
          acc_r <= lvl_s[L][0];
          cnt_r <= 16'd1;
        end else begin
          acc_r <= combine(m_s[L], acc_r, lvl_s[L][0]);
          if (cnt_r != 16'hFFFF) begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
      end
    end
  end

  // result register: loads on a completed frame, holds otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      odata  <= {ACC_W{1'b0}};
      obeats <= 16'd0;
      ovalid <= 1'b0;
    end else begin
      ovalid <= acc_v_r & acc_l_r;
      if (acc_v_r & acc_l_r) begin
        odata  <= acc_r;
        obeats <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_reduce_tree.sv
// Directed bench for reduce_tree (N=4, W=16, ACC_W=32) with hand-computed results.
module tb_reduce_tree;

  logic        clock;
  logic        reset;
  logic [63:0] idata;
  logic        ivalid;
  logic [3:0]  ilane_en;
  logic        ilast;
  logic [1:0]  imode;
  logic [31:0] odata;
  logic        ovalid;
  logic [15:0] obeats;

  int n_checks = 0;
  int n_fails  = 0;
  int pulses   = 0;
  int p0       = 0;

  reduce_tree #(.N(4), .W(16), .ACC_W(32)) dut (
    .clock(clock), .reset(reset), .idata(idata), .ivalid(ivalid),
    .ilane_en(ilane_en), .ilast(ilast), .imode(imode),
    .odata(odata), .ovalid(ovalid), .obeats(obeats)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ovalid === 1'b1) pulses++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] en,
                      input logic last, input logic [1:0] m);
    idata    = d;
    ilane_en = en;
    ilast    = last;
    imode    = m;
    ivalid   = 1'b1;
    step();
  endtask

  task automatic idle();
    ivalid = 1'b0;
    ilast  = 1'b0;
    step();
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (ovalid !== 1'b1 && n < 10) begin
      idle();
      n++;
    end
    chk({tag, "_ovalid"}, {31'd0, ovalid}, 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    idata    = 64'd0;
    ivalid   = 1'b0;
    ilane_en = 4'h0;
    ilast    = 1'b0;
    imode    = 2'd0;
    step(); step(); step();
    chk("rst_odata",  odata,            32'd0);
    chk("rst_ovalid", {31'd0, ovalid},  32'd0);
    chk("rst_obeats", {16'd0, obeats},  32'd0);
    reset = 1'b0;
    step();

    // single beat, exact latency
    beat(64'h0004_0003_0002_0001, 4'hF, 1'b1, 2'd0);
    idle();
    chk("lat_e1_ovalid", {31'd0, ovalid}, 32'd0);
    idle();
    chk("lat_e2_ovalid", {31'd0, ovalid}, 32'd0);
    idle();
    chk("lat_e3_ovalid", {31'd0, ovalid}, 32'd1);
    chk("single_odata",  odata,           32'd10);
    chk("single_obeats", {16'd0, obeats}, 32'd1);
    idle();
    chk("pulse_end_ovalid", {31'd0, ovalid}, 32'd0);
    chk("hold_odata",       odata,           32'd10);

    // multi-beat frame with an idle gap
    beat(64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 1'b0, 2'd0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 1'b0, 2'd0);
    idle();
    beat(64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 1'b1, 2'd0);
    wait_out("gap");
    chk("gap_odata",  odata,           32'hFFFF_FFF4);
    chk("gap_obeats", {16'd0, obeats}, 32'd3);

    // masked max / min
    beat(64'h0003_0064_FFF9_0005, 4'b1011, 1'b1, 2'd1);
    wait_out("max");
    chk("max_odata", odata, 32'd5);
    beat(64'h0003_0064_FFF9_0005, 4'b1011, 1'b1, 2'd2);
    wait_out("min");
    chk("min_odata", odata, 32'hFFFF_FFF9);

    // fully masked frames return the identity
    beat(64'h0003_0064_FFF9_0005, 4'h0, 1'b1, 2'd2);
    wait_out("mask_min");
    chk("mask_min_odata", odata, 32'h7FFF_FFFF);
    beat(64'h0003_0064_FFF9_0005, 4'h0, 1'b1, 2'd1);
    wait_out("mask_max");
    chk("mask_max_odata", odata, 32'h8000_0000);

    // mode lock plus back-to-back frames
    beat(64'h0001_0001_0001_0001, 4'hF, 1'b0, 2'd0);
    beat(64'h0002_0002_0002_0002, 4'hF, 1'b1, 2'd1);
    beat(64'h0000_0000_0000_0009, 4'hF, 1'b1, 2'd1);
    wait_out("b2b_a");
    chk("b2b_a_odata",  odata,           32'd12);
    chk("b2b_a_obeats", {16'd0, obeats}, 32'd2);
    idle();
    chk("b2b_b_ovalid", {31'd0, ovalid}, 32'd1);
    chk("b2b_b_odata",  odata,           32'd9);
    chk("b2b_b_obeats", {16'd0, obeats}, 32'd1);
    idle();
    chk("b2b_end_ovalid", {31'd0, ovalid}, 32'd0);

    // reset in the middle of a frame
    p0 = pulses;
    beat(64'h0005_0005_0005_0005, 4'hF, 1'b0, 2'd0);
    beat(64'h0005_0005_0005_0005, 4'hF, 1'b0, 2'd0);
    ivalid = 1'b0;
    reset  = 1'b1;
    #1;
    chk("midrst_odata", odata, 32'd0);
    step();
    reset = 1'b0;
    beat(64'h0001_0001_0001_0001, 4'hF, 1'b1, 2'd0);
    wait_out("midrst");
    chk("midrst_res_odata",  odata,           32'd4);
    chk("midrst_res_obeats", {16'd0, obeats}, 32'd1);
    idle(); idle(); idle(); idle();
    chk("midrst_pulses", pulses - p0, 32'd1);

    // beat counter saturation and modular sum wrap over 65541 beats
    for (int i = 0; i < 65540; i++) begin
      beat(64'h7FFF_7FFF_7FFF_7FFF, 4'hF, 1'b0, 2'd3);
    end
    beat(64'h7FFF_7FFF_7FFF_7FFF, 4'hF, 1'b1, 2'd3);
    wait_out("sat");
    chk("sat_obeats", {16'd0, obeats}, 32'h0000_FFFF);
    chk("wrap_odata", odata,           32'h0005_FFEC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
